pll_reset_sequencer: RTL

- Sequences the system PLL and the processor subsystem reset.
- Pulses the PLL async reset, waits for lock with a timeout and bounded retries, and requires lock to hold continuously before releasing the active-low system reset.
- Re-sequences automatically whenever lock is lost while running.
- Sits in the top level between the board reset, the PLL areset/locked export pair and the subsystem reset_n input.

---
 rtl/pll_reset_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Pulses the PLL async reset, waits for lock with a timeout and a bounded
// number of attempts, and requires lock to hold continuously for LOCK_STABLE
// cycles before releasing the active-low subsystem reset. Loss of lock while
// running re-sequences the PLL from scratch.
//
// Optional build macro: SEQ_SOFTKEY_EN
//   When defined, a debounced active-low push-button (key_n) returns the
//   sequencer from RUN to STABLE, re-asserting sys_reset_n for a full
//   stability window without touching the PLL.
//
// State encoding on seq_state: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

module pll_reset_sequencer #(
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 3,
  parameter int DEB_CYC      = 500000
) (
  input  logic       clk50m,
  input  logic       reset,
  input  logic       pll_locked,
`ifdef SEQ_SOFTKEY_EN
  input  logic       key_n,
`endif
  output logic       pll_areset,
  output logic       sys_reset_n,
  output logic [2:0] seq_state,
  output logic [1:0] retry_cnt,
  output logic       fail
);

  // Elaboration-time parameter sanity checks.
  if (PLL_RST_CYC < 1) begin : g_bad_rst_cyc
    $error("PLL_RST_CYC must be at least 1");
  end
  if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
    $error("LOCK_TIMEOUT must be at least 1");
  end
  if (LOCK_STABLE < 1) begin : g_bad_stable
    $error("LOCK_STABLE must be at least 1");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 4) begin : g_bad_retry
    $error("MAX_RETRY must be in 1..4");
  end
  if (DEB_CYC < 1) begin : g_bad_deb
    $error("DEB_CYC must be at least 1");
  end

  // One shared timer covers the longest per-state dwell.
  localparam int TMAX_A = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > LOCK_STABLE) ? TMAX_A : LOCK_STABLE;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_RST_LAST    = TW'(PLL_RST_CYC - 1);
  localparam logic [TW-1:0] T_LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_STABLE_LAST = TW'(LOCK_STABLE - 1);
  localparam logic [1:0]    RETRY_LAST    = 2'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [TW-1:0] timer_reg;
  logic [1:0]    retry_reg;
  logic [1:0]    retry_next;
  logic          pll_areset_reg;
  logic          sys_reset_n_reg;
  logic          fail_reg;
  logic          lock_meta_reg;
  logic          lock_s_reg;
  logic          soft_press;

  // Two-flop synchronizer for the PLL lock flag (asynchronous to clk50m).
  always_ff @(posedge clk50m) begin
    if (reset) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= pll_locked;
      lock_s_reg    <= lock_meta_reg;
    end
  end

`ifdef SEQ_SOFTKEY_EN
  localparam int            DW       = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic          key_meta_reg;
  logic          key_s_reg;
  logic [DW-1:0] low_cnt_reg;
  logic [DW-1:0] high_cnt_reg;
  logic          armed_reg;

  // A press fires on the DEB_CYC-th consecutive low sample, once per hold.
  assign soft_press = armed_reg && !key_s_reg && (low_cnt_reg == DEB_LAST);

  // Key synchronizer, run-length counters and the one-shot arming flag.
  always_ff @(posedge clk50m) begin
    if (reset) begin
      key_meta_reg <= 1'b1;
      key_s_reg    <= 1'b1;
      low_cnt_reg  <= '0;
      high_cnt_reg <= '0;
      armed_reg    <= 1'b1;
    end else begin
      key_meta_reg <= key_n;
      key_s_reg    <= key_meta_reg;
      if (!key_s_reg) begin
        high_cnt_reg <= '0;
        if (low_cnt_reg != DEB_LAST) begin
          low_cnt_reg <= low_cnt_reg + 1'b1;
        end
      end else begin
        low_cnt_reg <= '0;
        if (high_cnt_reg != DEB_LAST) begin
          high_cnt_reg <= high_cnt_reg + 1'b1;
        end
      end
      // Presses outside RUN still disarm; re-arm only after a full release.
      if (soft_press) begin
        armed_reg <= 1'b0;
      end else if (key_s_reg && (high_cnt_reg == DEB_LAST)) begin
        armed_reg <= 1'b1;
      end
    end
  end
`else
  assign soft_press = 1'b0;
`endif

  // Next-state and retry bookkeeping.
  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    case (state_reg)
      ST_PLL_RST: begin
        if (timer_reg == T_RST_LAST) begin
          state_next = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a timeout landing on the same cycle.
        if (lock_s_reg) begin
          state_next = ST_STABLE;
        end else if (timer_reg == T_LOCK_LAST) begin
          if (retry_reg == RETRY_LAST) begin
            state_next = ST_FAIL;
          end else begin
            retry_next = retry_reg + 2'd1;
            state_next = ST_PLL_RST;
          end
        end
      end
      ST_STABLE: begin
        // A lock dropout here is not a retry; the lock timeout just restarts.
        if (!lock_s_reg) begin
          state_next = ST_WAIT_LOCK;
        end else if (timer_reg == T_STABLE_LAST) begin
          state_next = ST_RUN;
          retry_next = 2'd0;
        end
      end
      ST_RUN: begin
        if (!lock_s_reg) begin
          state_next = ST_PLL_RST;
        end else if (soft_press) begin
          state_next = ST_STABLE;
        end
      end
      ST_FAIL: begin
        state_next = ST_FAIL;
      end
      default: begin
        state_next = ST_PLL_RST;
      end
    endcase
  end

  // State, retry count and glitch-free registered outputs.
  always_ff @(posedge clk50m) begin
    if (reset) begin
      state_reg       <= ST_PLL_RST;
      retry_reg       <= 2'd0;
      pll_areset_reg  <= 1'b1;
      sys_reset_n_reg <= 1'b0;
      fail_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      retry_reg       <= retry_next;
      pll_areset_reg  <= (state_next == ST_PLL_RST) || (state_next == ST_FAIL);
      sys_reset_n_reg <= (state_next == ST_RUN);
      fail_reg        <= (state_next == ST_FAIL);
    end
  end

  // Shared dwell timer: cleared on every state change, saturates otherwise.
  always_ff @(posedge clk50m) begin
    if (reset) begin
      timer_reg <= '0;
    end else if (state_next != state_reg) begin
      timer_reg <= '0;
    end else if (timer_reg != {TW{1'b1}}) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  assign pll_areset  = pll_areset_reg;
  assign sys_reset_n = sys_reset_n_reg;
  assign seq_state   = state_reg;
  assign retry_cnt   = retry_reg;
  assign fail        = fail_reg;

endmodule
